// File: rtl/fifo_dc_flags.sv
// fifo_dc_flags: per-domain empty/full flag generator for a dual-clock FIFO.
// Delays the synchronized used-word count through an optional register pipe
// and derives registered empty/full flags from it and the local requests.
module fifo_dc_flags #(
  parameter int    lpm_widthad        = 1,
  parameter int    lpm_numwords       = 1,
  parameter int    lpm_delay          = 1,
  parameter string underflow_checking = "ON",
  parameter string overflow_checking  = "ON",
  parameter string lpm_mode           = "READ"
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic [lpm_widthad-1:0] usedw_in,
  input  logic                   wreq,
  input  logic                   rreq,
  output logic [lpm_widthad-1:0] usedw,
  output logic                   empty,
  output logic                   full
);

  localparam int W = lpm_widthad;
  localparam int unsigned DLY = lpm_delay;
  localparam bit READ_MODE = (lpm_mode == "READ");
  localparam bit UNDER_ON  = (underflow_checking == "ON");
  localparam bit OVER_ON   = (overflow_checking == "ON");

  // Full threshold leaves margin for the cross-domain pipeline latency.
  localparam int FTH_I = (lpm_numwords > 3) ? (lpm_numwords - 3) :
                         ((lpm_numwords > 1) ? (lpm_numwords - 1) : 1);
  localparam logic [W-1:0] FTH = W'(FTH_I);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    NONEMPTY  = 2'b01,
    EMPTYWAIT = 2'b10
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_full;
  logic           r_lrreq;
  logic           r_lwreq;
  logic           w_rq;
  logic           w_wq;
  logic [W-1:0]   w_u;

  generate
    if (lpm_delay == 0) begin : g_nodelay
      assign w_u = usedw_in;
    end else begin : g_pipe
      logic [W-1:0] r_pipe [DLY];
      // Shift chain delaying usedw_in by lpm_delay clocks.
      always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
          for (int unsigned i = 0; i < DLY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= usedw_in;
          for (int unsigned i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_u = r_pipe[DLY-1];
    end
  endgenerate

  assign usedw = w_u;
  assign empty = (r_state != NONEMPTY);
  assign full  = r_full;
  assign w_rq  = UNDER_ON ? (rreq & ~empty) : rreq;
  assign w_wq  = OVER_ON  ? (wreq & ~r_full) : wreq;

  // State, full flag and last-request registers.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      r_state <= EMPTY;
      r_full  <= 1'b0;
      r_lrreq <= 1'b0;
      r_lwreq <= 1'b0;
    end else begin
      r_state <= w_next;
      r_full  <= (w_u >= FTH);
      r_lrreq <= w_rq;
      r_lwreq <= w_wq;
    end
  end

  // Empty state machine next-state logic; each mode uses only its own rules.
  always_comb begin
    w_next = r_state;
    if (READ_MODE) begin
      case (r_state)
        EMPTY:     if (w_u != '0) w_next = NONEMPTY;
        NONEMPTY:  if (w_rq && (((w_u == ONE) && !r_lrreq) ||
                               ((w_u == TWO) && r_lrreq)))
                     w_next = EMPTYWAIT;
        EMPTYWAIT: w_next = (w_u > ONE) ? NONEMPTY : EMPTY;
        default:   w_next = EMPTY;
      endcase
    end else begin
      case (r_state)
        EMPTY:     if (w_wq) w_next = NONEMPTY;
        NONEMPTY:  if ((w_u == '0) && !w_wq && !r_lwreq) w_next = EMPTY;
        default:   w_next = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_dc_flags.sv
// Directed testbench for fifo_dc_flags across several parameterisations.
module tb_fifo_dc_flags;

  logic       clock = 1'b0;
  logic       aclr  = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  // READ, depth 6 (FTH=3), delay 1
  logic [3:0] rd_uin = '0;
  logic       rd_rreq = 1'b0, rd_wreq = 1'b0;
  logic [3:0] rd_usedw;
  logic       rd_empty, rd_full;
  // READ, delay 3
  logic [3:0] d3_uin = '0;
  logic [3:0] d3_usedw;
  logic       d3_empty, d3_full;
  // READ, delay 0
  logic [3:0] d0_uin = '0;
  logic [3:0] d0_usedw;
  logic       d0_empty, d0_full;
  // WRITE, depth 16 (FTH=13)
  logic [3:0] wr_uin = '0;
  logic       wr_wreq = 1'b0, wr_rreq = 1'b0;
  logic [3:0] wr_usedw;
  logic       wr_empty, wr_full;
  // WRITE, depth 2 (FTH=1)
  logic [1:0] sm_uin = '0;
  logic       sm_wreq = 1'b0;
  logic [1:0] sm_usedw;
  logic       sm_empty, sm_full;

  always #5 clock = ~clock;

  fifo_dc_flags #(.lpm_widthad(4), .lpm_numwords(6), .lpm_delay(1), .lpm_mode("READ")) u_rd (
    .clock(clock), .aclr(aclr), .usedw_in(rd_uin), .wreq(rd_wreq), .rreq(rd_rreq),
    .usedw(rd_usedw), .empty(rd_empty), .full(rd_full));
  fifo_dc_flags #(.lpm_widthad(4), .lpm_numwords(16), .lpm_delay(3), .lpm_mode("READ")) u_d3 (
    .clock(clock), .aclr(aclr), .usedw_in(d3_uin), .wreq(1'b0), .rreq(1'b0),
    .usedw(d3_usedw), .empty(d3_empty), .full(d3_full));
  fifo_dc_flags #(.lpm_widthad(4), .lpm_numwords(16), .lpm_delay(0), .lpm_mode("READ")) u_d0 (
    .clock(clock), .aclr(aclr), .usedw_in(d0_uin), .wreq(1'b0), .rreq(1'b0),
    .usedw(d0_usedw), .empty(d0_empty), .full(d0_full));
  fifo_dc_flags #(.lpm_widthad(4), .lpm_numwords(16), .lpm_delay(1), .lpm_mode("WRITE")) u_wr (
    .clock(clock), .aclr(aclr), .usedw_in(wr_uin), .wreq(wr_wreq), .rreq(wr_rreq),
    .usedw(wr_usedw), .empty(wr_empty), .full(wr_full));
  fifo_dc_flags #(.lpm_widthad(2), .lpm_numwords(2), .lpm_delay(1), .lpm_mode("WRITE")) u_sm (
    .clock(clock), .aclr(aclr), .usedw_in(sm_uin), .wreq(sm_wreq), .rreq(1'b0),
    .usedw(sm_usedw), .empty(sm_empty), .full(sm_full));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    aclr = 1'b0;
    #12;
    chk("rst_rd_empty", {7'd0, rd_empty}, 8'd1);
    chk("rst_rd_full",  {7'd0, rd_full},  8'd0);
    chk("rst_wr_empty", {7'd0, wr_empty}, 8'd1);
    chk("rst_d3_usedw", {4'd0, d3_usedw}, 8'd0);
    @(negedge clock);
    aclr = 1'b1;
    tick(1);
    chk("rel_rd_empty", {7'd0, rd_empty}, 8'd1);
  endtask

  task automatic test_delay_pipe;
    d3_uin = 4'd7;
    tick(2);
    chk("d3_usedw_2clk", {4'd0, d3_usedw}, 8'd0);
    tick(1);
    chk("d3_usedw_3clk", {4'd0, d3_usedw}, 8'd7);
    d0_uin = 4'd9;
    #1;
    chk("d0_usedw_comb", {4'd0, d0_usedw}, 8'd9);
  endtask

  task automatic test_read_fill_drain;
    rd_uin = 4'd1;
    tick(1);
    chk("rd_fill_1clk", {7'd0, rd_empty}, 8'd1);
    tick(1);
    chk("rd_fill_2clk", {7'd0, rd_empty}, 8'd0);
    rd_rreq = 1'b1;
    tick(1);
    chk("rd_lastread_empty", {7'd0, rd_empty}, 8'd1);
    chk("rd_lastread_state", {6'd0, u_rd.r_state}, 8'd2);
    rd_uin = 4'd0;
    tick(2);
    chk("rd_hold_state", {6'd0, u_rd.r_state}, 8'd0);
    chk("rd_hold_lrreq", {7'd0, u_rd.r_lrreq}, 8'd0);
    chk("rd_hold_empty", {7'd0, rd_empty}, 8'd1);
    rd_rreq = 1'b0;
  endtask

  task automatic test_back_to_back;
    rd_uin = 4'd2;
    tick(2);
    chk("b2b_nonempty", {7'd0, rd_empty}, 8'd0);
    rd_rreq = 1'b1;
    tick(1);
    chk("b2b_first_read", {7'd0, rd_empty}, 8'd0);
    tick(1);
    chk("b2b_second_read", {6'd0, u_rd.r_state}, 8'd2);
    rd_rreq = 1'b0;
    rd_uin  = 4'd3;
    tick(2);
    chk("b2b_refill", {7'd0, rd_empty}, 8'd0);
    chk("b2b_full", {7'd0, rd_full}, 8'd1);
  endtask

  task automatic test_write_mode;
    wr_wreq = 1'b1;
    tick(1);
    chk("wr_empty_fall", {7'd0, wr_empty}, 8'd0);
    wr_wreq = 1'b0;
    wr_uin  = 4'd12;
    tick(2);
    chk("wr_full_12", {7'd0, wr_full}, 8'd0);
    wr_uin = 4'd13;
    tick(1);
    chk("wr_usedw_13", {4'd0, wr_usedw}, 8'd13);
    chk("wr_full_lag", {7'd0, wr_full}, 8'd0);
    tick(1);
    chk("wr_full_13", {7'd0, wr_full}, 8'd1);
    wr_wreq = 1'b1;
    tick(1);
    chk("wr_ovf_lwreq", {7'd0, u_wr.r_lwreq}, 8'd0);
    wr_wreq = 1'b0;
    wr_uin  = 4'd0;
    tick(1);
    chk("wr_drain_1clk", {7'd0, wr_empty}, 8'd0);
    tick(1);
    chk("wr_drain_2clk", {7'd0, wr_empty}, 8'd1);
    chk("wr_drain_full", {7'd0, wr_full}, 8'd0);
  endtask

  task automatic test_small_depth;
    sm_wreq = 1'b1;
    tick(1);
    chk("sm_empty_fall", {7'd0, sm_empty}, 8'd0);
    sm_wreq = 1'b0;
    sm_uin  = 2'd1;
    tick(1);
    chk("sm_full_lag", {7'd0, sm_full}, 8'd0);
    tick(1);
    chk("sm_full", {7'd0, sm_full}, 8'd1);
    sm_uin = 2'd0;
    tick(1);
    chk("sm_empty_1clk", {7'd0, sm_empty}, 8'd0);
    tick(1);
    chk("sm_empty_2clk", {7'd0, sm_empty}, 8'd1);
    chk("sm_full_clear", {7'd0, sm_full}, 8'd0);
  endtask

  task automatic test_reset_mid_run;
    rd_uin = 4'd5;
    tick(2);
    chk("mid_pre_usedw", {4'd0, rd_usedw}, 8'd5);
    chk("mid_pre_full",  {7'd0, rd_full},  8'd1);
    #2;
    aclr = 1'b0;
    #1;
    chk("mid_usedw", {4'd0, rd_usedw}, 8'd0);
    chk("mid_empty", {7'd0, rd_empty}, 8'd1);
    chk("mid_full",  {7'd0, rd_full},  8'd0);
    chk("mid_d3",    {4'd0, d3_usedw}, 8'd0);
  endtask

  initial begin
    test_reset;
    test_delay_pipe;
    test_read_fill_drain;
    test_back_to_back;
    test_write_mode;
    test_small_depth;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
